// File: rtl/aes_pkg.sv
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared constants, FSM encoding and helpers for the AES-128
//                iterative key schedule.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int         NR        = 10;
    localparam int         KW        = 128;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Word j of a round key; word 0 occupies the most significant 32 bits.
    function automatic logic [31:0] slot_word(input logic [KW-1:0] slot, input int unsigned j);
        return slot[KW-1-32*j -: 32];
    endfunction

    function automatic logic [3:0] prev_idx(input logic [3:0] rnd);
        return (rnd == 4'd0) ? 4'd0 : rnd - 4'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sbox.sv
// ============================================================================
//  Module      : aes_sbox
//  Description : Combinational AES forward S-box (GF(2^8) inverse + affine).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_data,
    output logic [7:0] o_data
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    logic [7:0] w_x2, w_x3, w_x6, w_x12, w_x15, w_x30, w_x60, w_x120, w_x240, w_x252;
    logic [7:0] w_inv;

    // Inverse as x^254 (maps 0 to 0 as required).
    assign w_x2   = gf_mul(i_data, i_data);
    assign w_x3   = gf_mul(w_x2, i_data);
    assign w_x6   = gf_mul(w_x3, w_x3);
    assign w_x12  = gf_mul(w_x6, w_x6);
    assign w_x15  = gf_mul(w_x12, w_x3);
    assign w_x30  = gf_mul(w_x15, w_x15);
    assign w_x60  = gf_mul(w_x30, w_x30);
    assign w_x120 = gf_mul(w_x60, w_x60);
    assign w_x240 = gf_mul(w_x120, w_x120);
    assign w_x252 = gf_mul(w_x240, w_x12);
    assign w_inv  = gf_mul(w_x252, w_x2);

    assign o_data = w_inv
                  ^ {w_inv[6:0], w_inv[7]}
                  ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]}
                  ^ {w_inv[3:0], w_inv[7:4]}
                  ^ 8'h63;

endmodule

`default_nettype wire

// File: rtl/aes_key_expand_seq.sv
// ============================================================================
//  Module      : aes_key_expand_seq
//  Description : Iterative AES-128 key schedule, one round key per clock,
//                driving a flat 11-slot round key bus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_key_expand_seq
    import aes_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            kld,
    input  logic [127:0]    key,
    output logic [0:1407]   round_keys,
    output logic            keys_valid,
    output logic            busy
);

    localparam logic [3:0] c_last_rnd = 4'(NR);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [KW-1:0] r_slot [0:NR];
    logic [3:0]    r_rnd;
    logic [7:0]    r_rcon;
    logic          r_keys_valid;
    logic          r_busy;

    logic          w_load;
    logic          w_step;
    logic [KW-1:0] w_prev;
    logic [KW-1:0] w_next;
    logic [31:0]   w_w3, w_rot, w_sub, w_t;
    logic [31:0]   w_n0, w_n1, w_n2, w_n3;

    assign w_prev = r_slot[prev_idx(r_rnd)];
    assign w_w3   = slot_word(w_prev, 3);
    assign w_rot  = {w_w3[23:0], w_w3[31:24]};

    for (genvar j = 0; j < 4; j++) begin : g_sbox
        aes_sbox u_sbox (
            .i_data (w_rot[31-8*j -: 8]),
            .o_data (w_sub[31-8*j -: 8])
        );
    end

    assign w_t    = w_sub ^ {r_rcon, 24'h000000};
    assign w_n0   = slot_word(w_prev, 0) ^ w_t;
    assign w_n1   = slot_word(w_prev, 1) ^ w_n0;
    assign w_n2   = slot_word(w_prev, 2) ^ w_n1;
    assign w_n3   = w_w3 ^ w_n2;
    assign w_next = {w_n0, w_n1, w_n2, w_n3};

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // A new key load wins in every state, including mid-expansion.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (kld) begin
                    w_load      = 1'b1;
                    w_state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                if (kld) begin
                    w_load = 1'b1;
                end else begin
                    w_step = 1'b1;
                    if (r_rnd == c_last_rnd) w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i <= NR; i++) r_slot[i] <= '0;
            r_rnd        <= 4'd0;
            r_rcon       <= RCON_INIT;
            r_keys_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else if (w_load) begin
            r_slot[0]    <= key;
            r_rnd        <= 4'd1;
            r_rcon       <= RCON_INIT;
            r_keys_valid <= 1'b0;
            r_busy       <= 1'b1;
        end else if (w_step) begin
            r_slot[r_rnd] <= w_next;
            if (r_rnd == c_last_rnd) begin
                r_keys_valid <= 1'b1;
                r_busy       <= 1'b0;
            end else begin
                r_rnd  <= r_rnd + 4'd1;
                r_rcon <= xtime(r_rcon);
            end
        end
    end

    for (genvar i = 0; i <= NR; i++) begin : g_out
        assign round_keys[KW*i +: KW] = r_slot[i];
    end

    assign keys_valid = r_keys_valid;
    assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_aes_key_expand_seq.sv
// ============================================================================
//  Module      : tb_aes_key_expand_seq
//  Description : Self-checking bench for aes_key_expand_seq against a
//                word-level FIPS-197 key schedule model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_aes_key_expand_seq;

    localparam logic [127:0] c_key_a1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic           clk = 1'b0;
    logic           reset;
    logic           kld;
    logic [127:0]   key;
    logic [0:1407]  round_keys;
    logic           keys_valid;
    logic           busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string        name;
        logic [127:0] key;
        logic [127:0] slot1;
        logic [127:0] slot10;
    } vec_t;

    always #5 clk = ~clk;

    aes_key_expand_seq dut (
        .clk        (clk),
        .reset      (reset),
        .kld        (kld),
        .key        (key),
        .round_keys (round_keys),
        .keys_valid (keys_valid),
        .busy       (busy)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
        end
        return p;
    endfunction

    // Inverse found by exhaustive search, then the bitwise affine map.
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] y;
        logic [7:0] c63;
        c63 = 8'h63;
        inv = 8'h00;
        for (int c = 1; c < 256; c++)
            if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
        for (int i = 0; i < 8; i++)
            y[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
        return y;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
    endfunction

    function automatic logic [0:1407] ref_schedule(input logic [127:0] k);
        logic [31:0]   w [0:43];
        logic [31:0]   tmp;
        logic [7:0]    rc;
        logic [0:1407] flat;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 44; i++) flat[32*i +: 32] = w[i];
        return flat;
    endfunction

    function automatic logic [127:0] slot_of(input logic [0:1407] f, input int i);
        return f[128*i +: 128];
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [0:1407] rks);
        logic [7:0]   s [0:16-1];
        logic [7:0]   t [0:16-1];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] blk;
        blk = pt ^ slot_of(rks, 0);
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_ref(blk[127-8*i -: 8]);
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) t[4*c+rr] = s[4*((c+rr)%4)+rr];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r != 10) begin
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = s[i];
            blk = blk ^ slot_of(rks, r);
        end
        return blk;
    endfunction

    task automatic cmp128(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cmp_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_schedule(input string nm, input logic [127:0] k);
        logic [0:1407] exp;
        exp = ref_schedule(k);
        for (int i = 0; i <= 10; i++)
            cmp128($sformatf("%s slot%0d", nm, i), slot_of(round_keys, i), slot_of(exp, i));
    endtask

    // Called just after the edge that sampled the last kld.
    task automatic wait_done(output int lat, output int busy_cyc);
        lat      = 0;
        busy_cyc = 0;
        while (!keys_valid && lat < 40) begin
            if (busy) busy_cyc++;
            tick;
            lat++;
        end
    endtask

    task automatic load_and_wait(input logic [127:0] k, output int lat, output int busy_cyc);
        kld = 1'b1;
        key = k;
        tick;
        kld = 1'b0;
        wait_done(lat, busy_cyc);
    endtask

    initial begin
        vec_t          vecs [0:1];
        int            lat;
        int            bc;
        logic [127:0]  rk;
        logic [0:1407] exp_a1;
        logic [0:1407] exp_zero;

        vecs[0] = '{"fips_a1", c_key_a1,
                    128'ha0fafe1788542cb123a339392a6c7605,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{"zero_key", 128'h0,
                    128'h62636363626363636263636362636363,
                    128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        exp_a1   = ref_schedule(c_key_a1);
        exp_zero = ref_schedule(128'h0);

        // Reset with kld asserted must not load.
        reset = 1'b0;
        kld   = 1'b1;
        key   = c_key_a1;
        repeat (3) tick;
        cmp_int("reset round_keys zero", int'(|round_keys), 0);
        cmp_int("reset keys_valid", int'(keys_valid), 0);
        cmp_int("reset busy", int'(busy), 0);
        reset = 1'b1;
        kld   = 1'b0;
        tick;
        cmp_int("post-reset busy", int'(busy), 0);
        cmp_int("post-reset round_keys zero", int'(|round_keys), 0);

        for (int v = 0; v < 2; v++) begin
            load_and_wait(vecs[v].key, lat, bc);
            cmp_int({vecs[v].name, " latency"}, lat, 10);
            cmp_int({vecs[v].name, " busy cycles"}, bc, 10);
            cmp_int({vecs[v].name, " busy after done"}, int'(busy), 0);
            cmp128({vecs[v].name, " slot1 const"}, slot_of(round_keys, 1), vecs[v].slot1);
            cmp128({vecs[v].name, " slot10 const"}, slot_of(round_keys, 10), vecs[v].slot10);
            check_schedule(vecs[v].name, vecs[v].key);
        end
        // Round 9 of the zero key uses rcon 8'h1B.
        cmp128("zero_key slot9 const", slot_of(round_keys, 9),
               128'hb1d4d8e28a7db9da1d7bb3de4c664941);

        // Abort: zero key, then A.1 key on the 5th expansion edge.
        kld = 1'b1;
        key = 128'h0;
        tick;
        kld = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick;
            cmp_int("abort keys_valid early", int'(keys_valid), 0);
        end
        load_and_wait(c_key_a1, lat, bc);
        cmp_int("abort latency", lat, 10);
        check_schedule("abort", c_key_a1);

        repeat (20) tick;
        for (int i = 0; i <= 10; i++)
            cmp128($sformatf("hold slot%0d", i), slot_of(round_keys, i), slot_of(exp_a1, i));
        cmp_int("hold keys_valid", int'(keys_valid), 1);
        cmp128("chain ciphertext", aes_encrypt(128'h3243f6a8885a308d313198a2e0370734, round_keys),
               128'h3925841d02dc09fbdc118597196a0b32);

        // Partially expanded: new slots written, later slots stale.
        kld = 1'b1;
        key = 128'h0;
        tick;
        kld = 1'b0;
        tick;
        tick;
        cmp128("partial slot2 new", slot_of(round_keys, 2), slot_of(exp_zero, 2));
        cmp128("partial slot7 stale", slot_of(round_keys, 7), slot_of(exp_a1, 7));
        cmp_int("partial busy", int'(busy), 1);
        tick;

        // Reset mid-expansion beats a simultaneous kld.
        reset = 1'b0;
        kld   = 1'b1;
        key   = c_key_a1;
        tick;
        cmp_int("midreset round_keys zero", int'(|round_keys), 0);
        cmp_int("midreset busy", int'(busy), 0);
        cmp_int("midreset keys_valid", int'(keys_valid), 0);
        reset = 1'b1;
        kld   = 1'b0;
        tick;
        rk = {$urandom, $urandom, $urandom, $urandom};
        load_and_wait(rk, lat, bc);
        cmp_int("after reset latency", lat, 10);
        check_schedule("after reset", rk);

        // kld held high restarts every cycle.
        kld = 1'b1;
        for (int c = 0; c < 12; c++) begin
            rk  = {$urandom, $urandom, $urandom, $urandom};
            key = rk;
            tick;
            cmp_int("held kld keys_valid", int'(keys_valid), 0);
            cmp_int("held kld busy", int'(busy), 1);
            cmp128("held kld slot0", slot_of(round_keys, 0), rk);
        end
        kld = 1'b0;
        wait_done(lat, bc);
        cmp_int("held kld release latency", lat, 10);
        check_schedule("held kld", rk);

        for (int n = 0; n < 5; n++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            load_and_wait(rk, lat, bc);
            cmp_int($sformatf("rand%0d latency", n), lat, 10);
            check_schedule($sformatf("rand%0d", n), rk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
